// File: rtl/adv7393_pixel_serializer_if.sv
// AXI-Stream word input carrying packed pixels into the ADV7393 serializer.
interface adv7393_pixel_serializer_if #(
  parameter int DWIDTH = 128
);
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adv7393_pixel_serializer.sv
// Word FIFO plus per-component serializer feeding the ADV7393 pixel bus.
// Each active-video cycle emits one Y or CbCr component, pixel 0 of a word first.
module adv7393_pixel_serializer #(
  parameter int                DWIDTH     = 128,
  parameter int                PIXEL_W    = 32,
  parameter int                COMP_W     = 8,
  parameter int                OUT_DWIDTH = 10,
  parameter int                FIFO_DEPTH = 16,
  parameter int                REVERSE    = 0,
  parameter int                Y_FIRST    = 0,
  parameter logic [COMP_W-1:0] BLANK_Y    = '0,
  parameter logic [COMP_W-1:0] BLANK_C    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  adv7393_pixel_serializer_if.slave     s_axis,
  input  logic                          act,
  input  logic                          flush,
  input  logic                          clr_underflow,
  output logic [OUT_DWIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PPW    = DWIDTH / PIXEL_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PIX_S  = 2 * COMP_W;
  localparam int WORD_S = PIX_S * PPW;
  localparam int IW     = (PPW > 1) ? $clog2(PPW) : 1;

  logic [WORD_S-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [WORD_S-1:0] word_q, src;
  logic [IW-1:0]     idx;
  logic              phase, loaded;
  logic              empty, full, wr_en, pop, uf_set, have_word, last;
  logic [PIX_S-1:0]  pix;
  logic [COMP_W-1:0] comp;

  // Only the top 2*COMP_W bits of each slot ({Y, CbCr}) are kept.
  function automatic logic [WORD_S-1:0] pack_word(input logic [DWIDTH-1:0] d);
    logic [WORD_S-1:0] w;
    w = '0;
    for (int i = 0; i < PPW; i++)
      w[i*PIX_S +: PIX_S] = d[i*PIXEL_W + PIXEL_W - 1 -: PIX_S];
    return w;
  endfunction

  // Reversal acts on the component bits inside their left-aligned field.
  function automatic logic [OUT_DWIDTH-1:0] fmt(input logic [COMP_W-1:0] c);
    logic [COMP_W-1:0] r;
    for (int i = 0; i < COMP_W; i++)
      r[i] = (REVERSE != 0) ? c[COMP_W-1-i] : c[i];
    return OUT_DWIDTH'(r) << (OUT_DWIDTH - COMP_W);
  endfunction

  function automatic logic [COMP_W-1:0] blank_comp(input logic ph);
    return (ph ^ (Y_FIRST != 0)) ? BLANK_Y : BLANK_C;
  endfunction

  assign empty         = (count == '0);
  assign full          = count[AW];
  assign s_axis.tready = !rst && !full && !flush;
  assign wr_en         = s_axis.tvalid && s_axis.tready;
  assign have_word     = loaded || !empty;
  assign pop           = act && !flush && !loaded && !empty;
  assign uf_set        = act && !flush && !have_word;
  assign last          = phase && (idx == IW'(PPW - 1));
  assign src           = loaded ? word_q : mem[rd_ptr];
  assign level         = count;

  always_comb begin
    pix  = src[int'(idx)*PIX_S +: PIX_S];
    comp = (phase ^ (Y_FIRST != 0)) ? pix[PIX_S-1 -: COMP_W] : pix[COMP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= pack_word(s_axis.tdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_q     <= '0;
      idx        <= '0;
      phase      <= 1'b0;
      loaded     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= act;
      if (uf_set)
        underflow <= 1'b1;
      else if (clr_underflow)
        underflow <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        loaded <= 1'b0;
        idx    <= '0;
        phase  <= 1'b0;
        dout   <= fmt(blank_comp(1'b0));
      end else begin
        if (wr_en)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !pop)
          count <= count + (AW+1)'(1);
        else if (pop && !wr_en)
          count <= count - (AW+1)'(1);

        if (!act) begin
          // Leaving active video drops any partly sent word; queued words stay.
          dout   <= fmt(blank_comp(1'b0));
          idx    <= '0;
          phase  <= 1'b0;
          loaded <= 1'b0;
        end else if (have_word) begin
          dout <= fmt(comp);
          if (!loaded)
            word_q <= src;
          phase <= !phase;
          if (phase) begin
            if (last) begin
              idx    <= '0;
              loaded <= 1'b0;
            end else begin
              idx    <= idx + IW'(1);
              loaded <= 1'b1;
            end
          end else begin
            loaded <= 1'b1;
          end
        end else begin
          dout <= fmt(blank_comp(phase));
        end
      end
    end
  end

endmodule

// File: tb/tb_adv7393_pixel_serializer.sv
// Randomized and directed checks of the ADV7393 pixel serializer against a queue model.
module tb_adv7393_pixel_serializer;
  localparam int DW = 128;
  localparam int OW = 10;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adv7393_pixel_serializer_if #(.DWIDTH(DW)) s_if ();
  logic act, flush, clr;
  logic [OW-1:0] dout;
  logic dout_valid, underflow;
  logic [4:0] level;

  adv7393_pixel_serializer dut (
    .clk(clk), .rst(rst), .s_axis(s_if.slave), .act(act), .flush(flush),
    .clr_underflow(clr), .dout(dout), .dout_valid(dout_valid),
    .underflow(underflow), .level(level)
  );

  adv7393_pixel_serializer_if #(.DWIDTH(DW)) r_if ();
  logic act_r, flush_r, clr_r;
  logic [OW-1:0] dout_r;
  logic dout_valid_r, underflow_r;
  logic [4:0] level_r;

  adv7393_pixel_serializer #(.REVERSE(1), .Y_FIRST(1)) dut_r (
    .clk(clk), .rst(rst), .s_axis(r_if.slave), .act(act_r), .flush(flush_r),
    .clr_underflow(clr_r), .dout(dout_r), .dout_valid(dout_valid_r),
    .underflow(underflow_r), .level(level_r)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued words and the components still owed from the current word.
  logic [DW-1:0] m_fifo[$];
  logic [OW-1:0] m_cur[$];
  logic [OW-1:0] e_dout = '0;
  logic          e_valid = 1'b0;
  logic          e_uf = 1'b0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic void split_word(input logic [DW-1:0] w);
    logic [31:0] slot;
    for (int p = 0; p < DW/32; p++) begin
      slot = w[p*32 +: 32];
      m_cur.push_back(OW'(slot[23:16]) * 4);
      m_cur.push_back(OW'(slot[31:24]) * 4);
    end
  endfunction

  task automatic tick();
    bit acc, uf_set;
    logic [DW-1:0] w;
    uf_set = 0;
    acc = s_if.tvalid && !flush && (m_fifo.size() < FD);
    if (flush) begin
      m_fifo.delete(); m_cur.delete(); e_dout = '0; acc = 0;
    end else if (!act) begin
      m_cur.delete(); e_dout = '0;
    end else if (m_cur.size() > 0) begin
      e_dout = m_cur.pop_front();
    end else if (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      split_word(w);
      e_dout = m_cur.pop_front();
    end else begin
      e_dout = '0; uf_set = 1;
    end
    if (acc) m_fifo.push_back(s_if.tdata);
    if (uf_set) e_uf = 1'b1;
    else if (clr) e_uf = 1'b0;
    e_valid = act;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; act = 0; flush = 0; clr = 0; s_if.tvalid = 0; s_if.tdata = '0;
    act_r = 0; flush_r = 0; clr_r = 0; r_if.tvalid = 0; r_if.tdata = '0;
    #2;
    n_tests++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", s_if.tready); end
    n_tests++; if (dout !== '0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %h/%b exp 000/0", dout, dout_valid); end
    n_tests++; if (level !== 5'd0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_level_uf got %0d/%b exp 0/0", level, underflow); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready got %b exp 1", s_if.tready); end
  endtask

  task automatic test_known_vector();
    logic [DW-1:0] w;
    logic [OW-1:0] exp_seq [8];
    exp_seq = '{10'h040, 10'h200, 10'h044, 10'h204, 10'h048, 10'h208, 10'h04C, 10'h20C};
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = {8'(8'h80 + i), 8'(8'h10 + i), 16'h0};
    s_if.tdata = w; s_if.tvalid = 1; tick(); s_if.tvalid = 0;
    act = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (dout !== exp_seq[k] || dout_valid !== 1'b1) begin
        n_fail++; $display("FAIL known_vec[%0d] got %h/%b exp %h/1", k, dout, dout_valid, exp_seq[k]);
      end
    end
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL known_vec_uf got %b exp 0", underflow); end
    act = 0; tick();
  endtask

  task automatic test_underflow();
    act = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (dout !== 10'h000 || dout_valid !== 1'b1 || underflow !== 1'b1) begin
        n_fail++; $display("FAIL underflow[%0d] got %h/%b/%b exp 000/1/1", k, dout, dout_valid, underflow);
      end
    end
    act = 0; tick(); tick();
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got %b exp 1", underflow); end
    act = 1; clr = 1; tick();
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set_wins got %b exp 1", underflow); end
    act = 0; tick(); clr = 0;
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", underflow); end
    e_uf = underflow;
  endtask

  task automatic test_fill();
    logic [DW-1:0] w17;
    for (int k = 0; k < 17; k++) begin
      s_if.tdata = rand_word(); s_if.tvalid = 1;
      #1;
      n_tests++;
      if (s_if.tready !== (k < FD)) begin n_fail++; $display("FAIL fill_tready[%0d] got %b exp %b", k, s_if.tready, k < FD); end
      if (k < 16) tick();
    end
    w17 = s_if.tdata;
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d exp 16", level); end
    act = 1; tick(); act = 0;
    n_tests++; if (s_if.tready !== 1'b1 || level !== 5'd15) begin n_fail++; $display("FAIL fill_after_pop got %b/%0d exp 1/15", s_if.tready, level); end
    tick(); s_if.tvalid = 0;
    n_tests++; if (level !== 5'd16 || m_fifo[FD-1] !== w17) begin n_fail++; $display("FAIL fill_17th_accept got level %0d exp 16", level); end
    act = 1;
    for (int k = 0; k < 16*8; k++) begin
      tick();
      n_tests++;
      if (dout !== e_dout) begin n_fail++; $display("FAIL fill_drain[%0d] got %h exp %h", k, dout, e_dout); end
    end
    act = 0; tick();
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL fill_drain_level got %0d exp 0", level); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin s_if.tdata = rand_word(); s_if.tvalid = 1; tick(); end
    s_if.tvalid = 0;
    n_tests++; if (level !== 5'd2) begin n_fail++; $display("FAIL b2b_preload got %0d exp 2", level); end
    act = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_tests++;
      if (dout !== e_dout || dout_valid !== 1'b1 || underflow !== 1'b0) begin
        n_fail++; $display("FAIL b2b[%0d] got %h/%b/%b exp %h/1/0", k, dout, dout_valid, underflow, e_dout);
      end
    end
    act = 0; tick();
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL b2b_level got %0d exp 0", level); end
  endtask

  task automatic test_act_drop();
    for (int k = 0; k < 2; k++) begin s_if.tdata = rand_word(); s_if.tvalid = 1; tick(); end
    s_if.tvalid = 0;
    act = 1;
    for (int k = 0; k < 3; k++) tick();
    act = 0; tick(); tick();
    act = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (dout !== e_dout) begin n_fail++; $display("FAIL act_drop[%0d] got %h exp %h", k, dout, e_dout); end
    end
    act = 0; tick();
  endtask

  task automatic test_random();
    int n_act = 0;
    for (int k = 0; k < 600; k++) begin
      if (n_act == 0) begin act = ~act; n_act = $urandom_range(1, 24); end
      n_act--;
      s_if.tvalid = ($urandom_range(0, 1) == 1);
      s_if.tdata  = rand_word();
      flush = ($urandom_range(0, 40) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      #1;
      n_tests++;
      if (s_if.tready !== (!flush && m_fifo.size() < FD)) begin n_fail++; $display("FAIL rand_tready[%0d] got %b", k, s_if.tready); end
      tick();
      n_tests++;
      if (dout !== e_dout || dout_valid !== e_valid || underflow !== e_uf || level !== 5'(m_fifo.size())) begin
        n_fail++;
        $display("FAIL rand[%0d] got %h/%b/%b/%0d exp %h/%b/%b/%0d", k, dout, dout_valid, underflow, level,
                 e_dout, e_valid, e_uf, m_fifo.size());
      end
    end
    act = 0; flush = 0; clr = 0; s_if.tvalid = 0; tick();
  endtask

  task automatic test_reset_midline();
    for (int k = 0; k < 3; k++) begin s_if.tdata = rand_word(); s_if.tvalid = 1; tick(); end
    s_if.tvalid = 0; act = 1;
    for (int k = 0; k < 3; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (dout !== '0 || dout_valid !== 1'b0 || level !== 5'd0 || underflow !== 1'b0 || s_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL midline_reset got %h/%b/%0d/%b/%b exp 000/0/0/0/0", dout, dout_valid, level, underflow, s_if.tready);
    end
    m_fifo.delete(); m_cur.delete(); e_uf = 0; act = 0;
    @(posedge clk); #1; rst = 1'b0;
    act = 1; tick(); act = 0;
    n_tests++; if (dout !== 10'h000 || underflow !== 1'b1) begin n_fail++; $display("FAIL midline_after got %h/%b exp 000/1", dout, underflow); end
    clr = 1; tick(); clr = 0; e_uf = 0;
  endtask

  task automatic test_reverse_flush();
    r_if.tdata = '0;
    r_if.tdata[31:0] = {8'h80, 8'h10, 16'h0};
    r_if.tvalid = 1; @(posedge clk); #1; r_if.tvalid = 0;
    act_r = 1; @(posedge clk); #1;
    n_tests++; if (dout_r !== 10'h004) begin n_fail++; $display("FAIL rev_first got %h exp 004", dout_r); end
    @(posedge clk); #1;
    n_tests++; if (dout_r !== 10'h020) begin n_fail++; $display("FAIL rev_second got %h exp 020", dout_r); end
    act_r = 0; @(posedge clk); #1;
    r_if.tdata = rand_word(); r_if.tvalid = 1; flush_r = 1; #1;
    n_tests++; if (r_if.tready !== 1'b0) begin n_fail++; $display("FAIL flush_tready got %b exp 0", r_if.tready); end
    @(posedge clk); #1; r_if.tvalid = 0; flush_r = 0;
    n_tests++; if (level_r !== 5'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", level_r); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_underflow();
    test_fill();
    test_back_to_back();
    test_act_drop();
    test_random();
    test_reset_midline();
    test_reverse_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1, "timeout");
  end
endmodule
